hazard_stall_ctrl: RTL

Central stall/flush sequencer for the 5-stage pipeline. Detects load-use hazards, sequences the multicycle multiplier in EX, and flushes wrong-path instructions on taken branch/jump resolved in MEM. Drives the enables and bubble/flush selects of PC, IF/ID, ID/EX and EX/MEM, and the ALU multiplier enable. Replaces the ad-hoc opcode-based NOP/stall insertion in IF.

---
 rtl/hazard_stall_ctrl_if.sv | 32 +++
 rtl/hazard_stall_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Bundle between the pipeline datapath and the stall/flush controller.
// The datapath drives hazard inputs; the controller returns enables, bubble/flush selects and its state.
interface hazard_stall_ctrl_if;
  logic [4:0] rs_id;
  logic [4:0] rt_id;
  logic       use_rt_id;
  logic       memread_ex;
  logic [4:0] rt_ex;
  logic       mul_ex;
  logic       redirect_mem;
  logic       en_pc;
  logic       en_ifid;
  logic       en_idex;
  logic       bubble_idex;
  logic       flush_ifid;
  logic       flush_exmem;
  logic       en_mul;
  logic       mul_done;
  logic [1:0] state_o;

  modport master (
    output rs_id, rt_id, use_rt_id, memread_ex, rt_ex, mul_ex, redirect_mem,
    input  en_pc, en_ifid, en_idex, bubble_idex, flush_ifid, flush_exmem,
           en_mul, mul_done, state_o
  );

  modport slave (
    input  rs_id, rt_id, use_rt_id, memread_ex, rt_ex, mul_ex, redirect_mem,
    output en_pc, en_ifid, en_idex, bubble_idex, flush_ifid, flush_exmem,
           en_mul, mul_done, state_o
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Central stall/flush sequencer: load-use stall, multicycle multiply hold, wrong-path flush.
// Define HAZARD_STATS_EN to add saturating stall_cnt/flush_cnt statistics outputs.
module hazard_stall_ctrl #(
  parameter int unsigned MUL_LAT = 32,
  parameter int unsigned CNT_W   = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  hazard_stall_ctrl_if.slave    hz
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MUL     = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               lu;
  logic               en_pc, en_ifid, en_idex;
  logic               bubble_idex, flush_ifid, flush_exmem;
  logic               en_mul, mul_done;

  assign lu = hz.memread_ex & (hz.rt_ex != '0) &
              ((hz.rt_ex == hz.rs_id) | (hz.use_rt_id & (hz.rt_ex == hz.rt_id)));

  always_comb begin
    en_pc       = 1'b1;
    en_ifid     = 1'b1;
    en_idex     = 1'b1;
    bubble_idex = 1'b0;
    flush_ifid  = 1'b0;
    flush_exmem = 1'b0;
    en_mul      = 1'b0;
    mul_done    = 1'b0;
    state_nxt   = state;
    cnt_nxt     = cnt;

    if (!rst) begin
      en_pc     = 1'b0;
      en_ifid   = 1'b0;
      en_idex   = 1'b0;
      state_nxt = ST_RUN;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (hz.redirect_mem) begin
            flush_ifid  = 1'b1;
            bubble_idex = 1'b1;
            flush_exmem = 1'b1;
            state_nxt   = ST_FLUSH;
          end else if (hz.mul_ex) begin
            en_pc       = 1'b0;
            en_ifid     = 1'b0;
            en_idex     = 1'b0;
            flush_exmem = 1'b1;
            en_mul      = 1'b1;
            cnt_nxt     = CNT_W'(MUL_LAT - 2);
            state_nxt   = ST_MUL;
          end else if (lu) begin
            en_pc       = 1'b0;
            en_ifid     = 1'b0;
            bubble_idex = 1'b1;
          end
        end
        ST_MUL: begin
          // A redirect here is not expected, but if seen it aborts the multiply.
          if (hz.redirect_mem) begin
            flush_ifid  = 1'b1;
            bubble_idex = 1'b1;
            flush_exmem = 1'b1;
            cnt_nxt     = '0;
            state_nxt   = ST_FLUSH;
          end else if (cnt == '0) begin
            en_mul    = 1'b1;
            mul_done  = 1'b1;
            state_nxt = ST_RUN;
          end else begin
            en_pc       = 1'b0;
            en_ifid     = 1'b0;
            en_idex     = 1'b0;
            flush_exmem = 1'b1;
            en_mul      = 1'b1;
            cnt_nxt     = cnt - 1'b1;
          end
        end
        ST_FLUSH: begin
          if (hz.redirect_mem) begin
            flush_ifid  = 1'b1;
            bubble_idex = 1'b1;
            flush_exmem = 1'b1;
          end else begin
            state_nxt = ST_RUN;
          end
        end
        default: begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign hz.en_pc       = en_pc;
  assign hz.en_ifid     = en_ifid;
  assign hz.en_idex     = en_idex;
  assign hz.bubble_idex = bubble_idex;
  assign hz.flush_ifid  = flush_ifid;
  assign hz.flush_exmem = flush_exmem;
  assign hz.en_mul      = en_mul;
  assign hz.mul_done    = mul_done;
  assign hz.state_o     = state;

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!en_pc && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
      if (flush_ifid && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule
